// File: rtl/t2mi_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : t2mi_dispatch_pkg
// Purpose  : Shared types, constants and helpers for the T2MI packet dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
package t2mi_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FWD     = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  // Destination is 3 bits wide so any NUM_DEST up to 8 fits.
  typedef struct packed {
    logic [2:0] dest;
    logic       first;
    logic       last;
    logic       abort;
    logic [7:0] data;
  } entry_t;

  localparam int         ENTRY_W    = $bits(entry_t);
  localparam logic [7:0] ABORT_DATA = 8'h00;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/t2mi_dispatch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : t2mi_dispatch_fifo
// Purpose  : Single-clock first-word-fall-through FIFO with full/empty/level.
// Revision : 1.0 - initial release
// ============================================================================
module t2mi_dispatch_fifo #(
  parameter  int WIDTH = 14,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en && (level_q != '0);
    // A full FIFO still takes a write when the head leaves in the same cycle.
    do_wr    = wr_en && ((level_q != FULL_LVL) || do_rd);
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    level_d  = level_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;

endmodule
`default_nettype wire

// File: rtl/t2mi_packet_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : t2mi_packet_dispatcher
// Purpose  : Routes parser packets by type to NUM_DEST consumers through a FIFO,
//            closing interrupted packets with an abort marker entry.
//            Statistics counters exist only with T2MI_DISPATCH_STATS_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module t2mi_packet_dispatcher
  import t2mi_dispatch_pkg::*;
#(
  parameter  int NUM_DEST   = 4,
  parameter  int FIFO_DEPTH = 64,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_start,
  input  logic [7:0]            in_type,
  input  logic [15:0]           in_length,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_end,
  input  logic                  in_sync_locked,
  input  logic [NUM_DEST*8-1:0] cfg_type,
  input  logic [NUM_DEST-1:0]   cfg_en,
  output logic [NUM_DEST-1:0]   out_valid,
  input  logic [NUM_DEST-1:0]   out_ready,
  output logic [7:0]            out_data,
  output logic                  out_first,
  output logic                  out_last,
  output logic                  out_abort,
  output logic [LVL_W-1:0]      fifo_level,
  output logic [15:0]           stat_fwd,
  output logic [15:0]           stat_drop,
  output logic [15:0]           stat_abort
);

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d, byte_cnt_q, byte_cnt_d;
  logic [2:0]  dest_q, dest_d;
  logic        abort_pend_q, abort_pend_d;

  entry_t      push_entry, head;
  logic        push, pop, can_push, fifo_full, fifo_empty;
  logic        abort_now, hdr_eval, match_hit;
  logic [2:0]  match_idx;
  logic        fwd_inc, drop_old, drop_new, abort_inc;

  t2mi_dispatch_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Descending scan so the lowest matching destination wins.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int d = NUM_DEST - 1; d >= 0; d--) begin
      if (cfg_en[d] && (cfg_type[8*d +: 8] == in_type)) begin
        match_hit = 1'b1;
        match_idx = 3'(d);
      end
    end
  end

  always_comb begin
    out_valid = '0;
    for (int d = 0; d < NUM_DEST; d++) begin
      out_valid[d] = !fifo_empty && (head.dest == 3'(d));
    end
    pop       = |(out_valid & out_ready);
    out_data  = fifo_empty ? 8'h00 : head.data;
    out_first = !fifo_empty && head.first;
    out_last  = !fifo_empty && head.last;
    out_abort = !fifo_empty && head.abort;
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    dest_d       = dest_q;
    abort_pend_d = abort_pend_q;
    push         = 1'b0;
    push_entry   = '0;
    fwd_inc      = 1'b0;
    drop_old     = 1'b0;
    drop_new     = 1'b0;
    abort_inc    = 1'b0;
    abort_now    = 1'b0;
    hdr_eval     = 1'b0;
    can_push     = !fifo_full || pop;

    if (abort_pend_q && can_push) begin
      push         = 1'b1;
      push_entry   = '{dest: dest_q, first: 1'b0, last: 1'b1, abort: 1'b1, data: ABORT_DATA};
      abort_pend_d = 1'b0;
      abort_inc    = 1'b1;
    end

    case (state_q)
      ST_IDLE: hdr_eval = in_start;
      ST_FWD: begin
        if (in_start) begin
          abort_now = 1'b1;
          hdr_eval  = 1'b1;
        end else if (!in_sync_locked) begin
          abort_now = 1'b1;
        end else if (in_valid) begin
          if (!can_push || push) begin
            abort_now = 1'b1;
          end else begin
            push       = 1'b1;
            push_entry = '{dest: dest_q, first: (byte_cnt_q == 16'd0),
                           last: (byte_cnt_q == len_q - 16'd1), abort: 1'b0, data: in_data};
            byte_cnt_d = byte_cnt_q + 16'd1;
            if (byte_cnt_q == len_q - 16'd1) begin
              state_d = ST_IDLE;
              fwd_inc = 1'b1;
            end else if (in_end) begin
              abort_now = 1'b1;
            end
          end
        end else if (in_end) begin
          abort_now = 1'b1;
        end
      end
      ST_DISCARD: begin
        if (in_start)    hdr_eval = 1'b1;
        else if (in_end) state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A packet with nothing delivered yet is dropped silently instead of marked.
    if (abort_now) begin
      state_d = ST_DISCARD;
      if (byte_cnt_d != 16'd0) begin
        if (!push && can_push) begin
          push       = 1'b1;
          push_entry = '{dest: dest_q, first: 1'b0, last: 1'b1, abort: 1'b1, data: ABORT_DATA};
          abort_inc  = 1'b1;
        end else begin
          abort_pend_d = 1'b1;
        end
      end else begin
        drop_old = 1'b1;
      end
    end

    // Headers are refused while a marker is still waiting, so that marker
    // never contends with the new packet's bytes for the single push slot.
    if (hdr_eval) begin
      len_d      = in_length;
      byte_cnt_d = '0;
      if (match_hit && in_sync_locked && !abort_pend_d && (in_length != 16'd0)) begin
        state_d = ST_FWD;
        dest_d  = match_idx;
      end else begin
        drop_new = 1'b1;
        state_d  = (match_hit && in_sync_locked && !abort_pend_d) ? ST_IDLE : ST_DISCARD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      dest_q       <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      dest_q       <= dest_d;
      abort_pend_q <= abort_pend_d;
    end
  end

`ifdef T2MI_DISPATCH_STATS_EN
  logic [15:0] stat_fwd_q, stat_fwd_d, stat_drop_q, stat_drop_d, stat_abort_q, stat_abort_d;

  // An in_start abort can drop the old and the new packet in one cycle.
  always_comb begin
    stat_fwd_d   = sat_inc(stat_fwd_q, fwd_inc);
    stat_drop_d  = sat_inc(sat_inc(stat_drop_q, drop_old), drop_new);
    stat_abort_d = sat_inc(stat_abort_q, abort_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fwd_q   <= '0;
      stat_drop_q  <= '0;
      stat_abort_q <= '0;
    end else begin
      stat_fwd_q   <= stat_fwd_d;
      stat_drop_q  <= stat_drop_d;
      stat_abort_q <= stat_abort_d;
    end
  end

  assign stat_fwd   = stat_fwd_q;
  assign stat_drop  = stat_drop_q;
  assign stat_abort = stat_abort_q;
`else
  logic unused_stat_inc;
  assign unused_stat_inc = fwd_inc ^ drop_old ^ drop_new ^ abort_inc;
  assign stat_fwd        = '0;
  assign stat_drop       = '0;
  assign stat_abort      = '0;
`endif

endmodule
`default_nettype wire

// File: doc/t2mi_packet_dispatcher.md
# t2mi_packet_dispatcher

Routes the byte stream from the T2MI packet parser to up to `NUM_DEST` downstream consumers, selected by packet type. It sits between the parser output and the per-type consumers (timestamp extractor, L1 decoder and others). The parser has no backpressure, so the block buffers bytes in a FIFO. When it cannot deliver a packet intact, it terminates that packet with an explicit abort marker.

## Interface
- `NUM_DEST`, 4: number of destinations (1..8).
- `FIFO_DEPTH`, 64: FIFO entries; power of two, at least 4.
- `clk` in 1: system clock (100 MHz).
- `rst_n` in 1: asynchronous active-low reset, single clock domain.
- `in_start` in 1: header strobe. `in_type` and `in_length` are valid in this cycle. It carries no data byte.
- `in_type` in 8: packet type.
- `in_length` in 16: number of payload bytes.
- `in_valid` in 1: `in_data` holds a payload byte.
- `in_data` in 8: payload byte.
- `in_end` in 1: end-of-packet strobe. It may coincide with the last `in_valid`.
- `in_sync_locked` in 1: parser sync status.
- `cfg_type` in `NUM_DEST*8`: type code accepted by destination d, in bits [8d+7:8d].
- `cfg_en` in `NUM_DEST`: destination enable, one bit per destination.
- `out_valid` out `NUM_DEST`: one-hot valid to the destination that owns the FIFO head entry.
- `out_ready` in `NUM_DEST`: consumer ready, one bit per destination.
- `out_data` out 8: shared data bus to all destinations.
- `out_first`, `out_last`, `out_abort` out 1 each: entry flags.
- `fifo_level` out log2(`FIFO_DEPTH`)+1: current FIFO occupancy.
- `stat_fwd`, `stat_drop`, `stat_abort` out 16 each: statistics counters.

## Operation
- **FIFO entry format:** {dest, first, last, abort, data}. Routing is stored per entry, so a new packet can be accepted while the previous one is still draining.
- **IDLE:**
  - On `in_start`, latch type and length and clear `byte_cnt`.
  - Destination = lowest d with `cfg_en[d]` set and `cfg_type[d] == in_type`.
  - If a destination matches and `in_sync_locked` = 1, go to FWD.
  - Otherwise go to DISCARD and increment `stat_drop`.
- **FWD:**
  - Each `in_valid` byte is pushed with first = (`byte_cnt` == 0) and last = (`byte_cnt` == length−1). `byte_cnt` then increments.
  - After the last byte, go to IDLE, increment `stat_fwd`, and ignore the remaining `in_end`.
  - `in_length` = 0 → no bytes are pushed; increment `stat_drop` and return to IDLE.
- **Abort conditions in FWD** (only if at least one byte of the packet has already been pushed):
  - `in_end` arrives before the last byte.
  - A byte arrives while the FIFO is full. That byte is lost.
  - `in_sync_locked` falls.
  - A new `in_start` arrives.
- **Abort handling:**
  - Set `abort_pend`. The block then pushes one marker entry {dest, first=0, last=1, abort=1, data=0x00} as soon as the FIFO is not full, and increments `stat_abort`.
  - If no byte had been pushed yet, the packet is simply dropped (`stat_drop`) with no marker.
  - After an abort, go to DISCARD. The exception is an abort caused by `in_start`: that new header is evaluated as in IDLE, unless `abort_pend` is still set, in which case the new packet goes to DISCARD and `stat_drop` increments.
- **DISCARD:**
  - Ignore input bytes.
  - Leave on `in_end` → IDLE, or on `in_start` → evaluate the header as in IDLE.
  - DISCARD never pushes anything except a pending marker.
- **Bytes beyond `in_length`** before `in_end` are ignored.
- **Output side:**
  - Head entry → `out_valid[dest]` = 1; all other `out_valid` bits are 0.
  - A pop happens on `out_valid[d] & out_ready[d]`.
  - The head waits indefinitely; there is no timeout.
- **Arithmetic:** `byte_cnt` is 16 bits. Statistics counters saturate at 0xFFFF.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty, `abort_pend` = 0.
  - `out_valid` = 0, `out_data` = 0x00, all flags 0.
  - `fifo_level` = 0, all statistics counters = 0.
- Latency: a byte pushed in cycle N is visible at the output in cycle N+1 if the FIFO was empty.
- The output holds steady while valid && !ready.
- Push and pop in the same cycle are allowed. In that case `fifo_level` is unchanged, and a full FIFO with a simultaneous pop accepts the push.
- `in_start` in the same cycle as `in_valid` is illegal from the parser; the byte is ignored.
- The marker push has priority over the data push, and at most one push happens per cycle.
- Reset asserted mid-packet clears everything immediately. Consumers must treat `rst_n` as an implicit abort.

## Configuration
- `T2MI_DISPATCH_STATS_EN`:
  - Defined: the three 16-bit saturating counters are implemented.
  - Undefined: `stat_fwd`, `stat_drop` and `stat_abort` are tied to 0 and no counter flops are built. Routing behaviour is identical either way.

## Structure
- `t2mi_dispatch_pkg` holds:
  - the FSM state enum (IDLE, FWD, DISCARD);
  - the FIFO entry struct;
  - `ABORT_DATA` = 8'h00;
  - the saturating-increment function.
- Sub-module `t2mi_dispatch_fifo`: synchronous first-word-fall-through FIFO with parameterised width and depth, and `full`, `empty` and `level` outputs.

## Test plan
- **Routing:** `cfg_type` = {0x40, 0x30, 0x20, 0x10}, all enabled. Send type 0x20, length 10, bytes 0xAA..0xB3 → `out_valid[1]` only, `out_first` on 0xAA, `out_last` on 0xB3, `stat_fwd` = 1.
- **Unmatched:** send type 0x99, length 5 → no `out_valid`, `stat_drop` = 1, FSM back in IDLE after `in_end`.
- **Backpressure overflow:** `FIFO_DEPTH` = 64, `out_ready[0]` = 0, type 0x10, length 100 → 64 data entries, then one abort marker once `out_ready` is released, `stat_abort` = 1.
- **Early end:** type 0x30, length 15, `in_end` after 7 bytes → 7 bytes then marker (`out_abort` = 1, `out_last` = 1, data 0x00) on `out_valid[2]`.
- **Back-to-back:** type 0x10 then type 0x40, each length 4, with both consumers always ready → 8 entries, correct per-entry destination, no abort.
- **Sync loss:** `in_sync_locked` drops after byte 3 of a 20-byte packet → marker is pushed, following bytes are ignored until the next `in_start`.
